// File: rtl/sfa_pkg.sv
// Shared constants, state type and the round-robin helper for the tile input arbiter.
package sfa_pkg;

   localparam logic [1:0] PORT_N      = 2'd0;
   localparam logic [1:0] PORT_E      = 2'd1;
   localparam logic [1:0] PORT_S      = 2'd2;
   localparam logic [1:0] PORT_W      = 2'd3;
   localparam int         CONF_RR_BIT = 2;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   // Returns {found, port}. The port is the first valid one found when scanning
   // upward from last+1, wrapping, with last itself checked at the very end.
   function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] valid);
      logic [2:0] result;
      logic [1:0] idx;
      result = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (valid[idx]) result = {1'b1, idx};
      end
      return result;
   endfunction

endpackage

// File: rtl/sfa_axis_skid.sv
// Two-entry AXI-Stream register slice. The upstream ready is a flop holding
// "not full", so nothing combinational runs from m_tready to s_tready.
module sfa_axis_skid #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  s_tvalid,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   output logic                  s_tready,
   output logic                  m_tvalid,
   output logic [DATA_WIDTH-1:0] m_tdata,
   input  logic                  m_tready
);

   logic [1:0]            count;
   logic [1:0]            count_next;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;
   logic                  push;
   logic                  pop;

   assign push     = s_tvalid & s_tready;
   assign pop      = m_tvalid & m_tready;
   assign m_tvalid = (count != 2'd0);
   assign m_tdata  = head;

   // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 2'd1;
      end else if (pop && !push) begin
         count_next = count - 2'd1;
      end
   end

   // Head always drives the output; the tail only holds the beat caught while stalled.
   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= 2'd0;
         head     <= '0;
         tail     <= '0;
         s_tready <= 1'b0;
      end else begin
         count    <= count_next;
         s_tready <= (count_next != 2'd2);
         if (push && !pop) begin
            if (count == 2'd0) begin
               head <= s_tdata;
            end else begin
               tail <= s_tdata;
            end
         end else if (pop && !push) begin
            head <= tail;
         end else if (push && pop) begin
            if (count == 2'd1) begin
               head <= s_tdata;
            end else begin
               head <= tail;
               tail <= s_tdata;
            end
         end
      end
   end

endmodule

// File: rtl/sfa_in_arbiter.sv
// Tile input arbiter: merges the N/E/S/W streams onto one output, using either
// a fixed port or burst-granular round-robin, and drives the output through a skid slice.
module sfa_in_arbiter
   import sfa_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [2:0]            CONF,
   input  logic                  sn_tvalid,
   input  logic [DATA_WIDTH-1:0] sn_tdata,
   output logic                  sn_tready,
   input  logic                  se_tvalid,
   input  logic [DATA_WIDTH-1:0] se_tdata,
   output logic                  se_tready,
   input  logic                  ss_tvalid,
   input  logic [DATA_WIDTH-1:0] ss_tdata,
   output logic                  ss_tready,
   input  logic                  sw_tvalid,
   input  logic [DATA_WIDTH-1:0] sw_tdata,
   output logic                  sw_tready,
   input  logic                  mo_tready,
   output logic                  mo_tvalid,
   output logic [DATA_WIDTH-1:0] mo_tdata,
   output logic [1:0]            grant,
   output logic                  busy
);

   localparam int              CNT_W    = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   arb_state_t            state;
   logic [1:0]            grant_q;
   logic [1:0]            rr_last;
   logic                  rr_mode;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  locked;
   logic [3:0]            in_valid;
   logic [DATA_WIDTH-1:0] in_data [4];
   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [2:0]            rr_choice;
   logic                  pick_valid;
   logic [1:0]            pick_port;
   logic                  skid_ready;
   logic                  skid_in_valid;
   logic                  accept;
   logic                  release_burst;

   assign in_valid   = {sw_tvalid, ss_tvalid, se_tvalid, sn_tvalid};
   assign in_data[0] = sn_tdata;
   assign in_data[1] = se_tdata;
   assign in_data[2] = ss_tdata;
   assign in_data[3] = sw_tdata;

   assign locked        = (state == ARB_LOCKED);
   assign skid_in_valid = locked & sel_valid;
   assign accept        = locked & sel_valid & skid_ready;
   assign release_burst = locked & ((rr_mode & accept & (beat_cnt == CNT_LAST)) |
                                    (~sel_valid & skid_ready));

   assign sn_tready = locked & skid_ready & (grant_q == PORT_N);
   assign se_tready = locked & skid_ready & (grant_q == PORT_E);
   assign ss_tready = locked & skid_ready & (grant_q == PORT_S);
   assign sw_tready = locked & skid_ready & (grant_q == PORT_W);
   assign grant     = grant_q;
   assign busy      = locked;

   // Route the currently granted input towards the skid slice.
   always_comb begin
      sel_valid = in_valid[grant_q];
      sel_data  = in_data[grant_q];
   end

   // Candidate for the next grant: the configured port, or the next valid port after rr_last.
   always_comb begin
      rr_choice  = rr_pick(rr_last, in_valid);
      pick_port  = CONF[1:0];
      pick_valid = in_valid[CONF[1:0]];
      if (CONF[CONF_RR_BIT]) begin
         pick_port  = rr_choice[1:0];
         pick_valid = rr_choice[2];
      end
   end

   // Arbiter FSM: CONF is sampled only when a grant is made; a burst ends on its last beat or on a gap.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state    <= ARB_IDLE;
         grant_q  <= PORT_N;
         rr_last  <= PORT_W;
         rr_mode  <= 1'b0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  grant_q  <= pick_port;
                  rr_mode  <= CONF[CONF_RR_BIT];
                  beat_cnt <= '0;
                  state    <= ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
               if (release_burst) begin
                  rr_last <= grant_q;
                  state   <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   sfa_axis_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clock   (ACLK),
      .reset   (ARESET),
      .s_tvalid(skid_in_valid),
      .s_tdata (sel_data),
      .s_tready(skid_ready),
      .m_tvalid(mo_tvalid),
      .m_tdata (mo_tdata),
      .m_tready(mo_tready)
   );

endmodule
